// File: rtl/vending_controller_pkg.sv
// Shared types, code constants and price/coin helpers for the vending controller.
// Display state codes here must match what the 7-segment stage decodes.
package vending_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TYPE      = 3'd1,
    S_PAY       = 3'd2,
    S_ERR_CODE  = 3'd3,
    S_ERR_VALUE = 3'd4
  } state_t;

  localparam logic [2:0] ST_OPEN = 3'd0;
  localparam logic [2:0] ST_E404 = 3'd1;
  localparam logic [2:0] ST_E405 = 3'd2;
  localparam logic [2:0] ST_COIN = 3'd3;
  localparam logic [2:0] ST_TYPE = 3'd4;

  localparam logic [3:0] KEY_CONFIRM = 4'd10;
  localparam logic [3:0] KEY_CANCEL  = 4'd11;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = 5'd1;
      2'd1:    coin_value = 5'd2;
      2'd2:    coin_value = 5'd5;
      default: coin_value = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] price(input logic [1:0] n1, input logic [1:0] n2);
    price = {1'b0, n1, 2'b00} + {3'b000, n2};
  endfunction

  // Any two-bit second digit is a valid column; only row 0 is unpopulated.
  function automatic logic code_valid(input logic [1:0] n1);
    code_valid = (n1 != 2'd0);
  endfunction

  function automatic logic [2:0] estado_of(input state_t st);
    case (st)
      S_IDLE:      estado_of = ST_OPEN;
      S_TYPE:      estado_of = ST_TYPE;
      S_PAY:       estado_of = ST_COIN;
      S_ERR_CODE:  estado_of = ST_E404;
      S_ERR_VALUE: estado_of = ST_E405;
      default:     estado_of = ST_OPEN;
    endcase
  endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Keypad/coin inputs and display/dispense outputs of the vending controller.
interface vending_controller_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic [2:0] estado;
  logic [1:0] num1;
  logic [1:0] num2;
  logic [4:0] credit;
  logic       dispense;
  logic       change_valid;
  logic [4:0] change;
  logic       coin_reject;

  modport master (
    output key_valid, key_code, coin_valid, coin_code,
    input  estado, num1, num2, credit, dispense, change_valid, change, coin_reject
  );

  modport slave (
    input  key_valid, key_code, coin_valid, coin_code,
    output estado, num1, num2, credit, dispense, change_valid, change, coin_reject
  );
endinterface

// File: rtl/vending_controller_hold_timer.sv
// Loadable down-counter shared by the error-screen hold and the typing timeout.
// expired is high in the cycle before the count reaches zero, so the owner leaves on that edge.
module vending_controller_hold_timer #(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          expired
);

  logic [TW-1:0] count_r;

  // Count register: load wins, otherwise decrement down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {{(TW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/vending_controller.sv
// Vending-machine control FSM: code entry, validation, coin accumulation, dispense and change.
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int ERR_CYCLES     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int TW             = 28
) (
  input logic                 clk,
  input logic                 rst,
  vending_controller_if.slave bus
);

  localparam logic [TW-1:0] ERR_LOAD     = TW'(ERR_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  state_t        state_r, state_s;
  logic [1:0]    num1_r, num1_s, num2_r, num2_s;
  logic [4:0]    credit_r, credit_s, change_r, change_s, sum_s;
  logic          two_r, two_s;
  logic          dispense_r, dispense_s, change_valid_r, change_valid_s;
  logic          coin_reject_r, coin_reject_s;
  logic [2:0]    estado_r;
  logic          tmr_load_s, tmr_expired_s, key_digit_s, key_low_s;
  logic [TW-1:0] tmr_value_s;

  vending_controller_hold_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .expired    (tmr_expired_s)
  );

  // Next-state and next-output logic; a coin is always resolved before a key in PAY.
  always_comb begin
    state_s        = state_r;
    num1_s         = num1_r;
    num2_s         = num2_r;
    credit_s       = credit_r;
    two_s          = two_r;
    change_s       = change_r;
    dispense_s     = 1'b0;
    change_valid_s = 1'b0;
    coin_reject_s  = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_value_s    = TIMEOUT_LOAD;
    sum_s          = credit_r + coin_value(bus.coin_code);
    key_digit_s    = bus.key_valid && (bus.key_code <= 4'd9);
    key_low_s      = (bus.key_code <= 4'd3);
    case (state_r)
      S_IDLE: begin
        num1_s        = 2'd0;
        num2_s        = 2'd0;
        credit_s      = 5'd0;
        coin_reject_s = bus.coin_valid;
        if (key_digit_s && key_low_s) begin
          num1_s     = bus.key_code[1:0];
          two_s      = 1'b0;
          state_s    = S_TYPE;
          tmr_load_s = 1'b1;
        end else if (key_digit_s) begin
          state_s     = S_ERR_CODE;
          tmr_load_s  = 1'b1;
          tmr_value_s = ERR_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_TYPE: begin
        coin_reject_s = bus.coin_valid;
        state_s       = tmr_expired_s ? S_IDLE : S_TYPE;
        if (key_digit_s && !key_low_s) begin
          state_s     = S_ERR_CODE;
          tmr_load_s  = 1'b1;
          tmr_value_s = ERR_LOAD;
        end else if (key_digit_s && !two_r) begin
          num2_s     = bus.key_code[1:0];
          two_s      = 1'b1;
          state_s    = S_TYPE;
          tmr_load_s = 1'b1;
        end else if (bus.key_valid && (bus.key_code == KEY_CONFIRM)) begin
          if (two_r && code_valid(num1_r)) begin
            state_s = S_PAY;
          end else begin
            state_s     = S_ERR_CODE;
            tmr_load_s  = 1'b1;
            tmr_value_s = ERR_LOAD;
          end
        end else if (bus.key_valid && (bus.key_code == KEY_CANCEL)) begin
          state_s = S_IDLE;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      S_PAY: begin
        if (bus.coin_valid && (bus.coin_code == 2'd3)) begin
          change_valid_s = 1'b1;
          change_s       = credit_r;
          credit_s       = 5'd0;
          state_s        = S_ERR_VALUE;
          tmr_load_s     = 1'b1;
          tmr_value_s    = ERR_LOAD;
        end else if (bus.coin_valid && (sum_s >= price(num1_r, num2_r))) begin
          dispense_s     = 1'b1;
          change_valid_s = 1'b1;
          change_s       = sum_s - price(num1_r, num2_r);
          credit_s       = 5'd0;
          state_s        = S_IDLE;
        end else if (bus.key_valid && (bus.key_code == KEY_CANCEL)) begin
          change_valid_s = 1'b1;
          change_s       = bus.coin_valid ? sum_s : credit_r;
          credit_s       = 5'd0;
          state_s        = S_IDLE;
        end else if (bus.coin_valid) begin
          credit_s = sum_s;
        end else begin
          credit_s = credit_r;
        end
      end
      S_ERR_CODE, S_ERR_VALUE: begin
        coin_reject_s = bus.coin_valid;
        if (tmr_expired_s) begin
          state_s = S_IDLE;
          num1_s  = 2'd0;
          num2_s  = 2'd0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; every output is driven from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      num1_r         <= 2'd0;
      num2_r         <= 2'd0;
      credit_r       <= 5'd0;
      two_r          <= 1'b0;
      change_r       <= 5'd0;
      dispense_r     <= 1'b0;
      change_valid_r <= 1'b0;
      coin_reject_r  <= 1'b0;
      estado_r       <= ST_OPEN;
    end else begin
      state_r        <= state_s;
      num1_r         <= num1_s;
      num2_r         <= num2_s;
      credit_r       <= credit_s;
      two_r          <= two_s;
      change_r       <= change_s;
      dispense_r     <= dispense_s;
      change_valid_r <= change_valid_s;
      coin_reject_r  <= coin_reject_s;
      estado_r       <= estado_of(state_s);
    end
  end

  assign bus.estado       = estado_r;
  assign bus.num1         = num1_r;
  assign bus.num2         = num2_r;
  assign bus.credit       = credit_r;
  assign bus.dispense     = dispense_r;
  assign bus.change_valid = change_valid_r;
  assign bus.change       = change_r;
  assign bus.coin_reject  = coin_reject_r;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller with short error/timeout holds (8 and 16 cycles).
module tb_vending_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vending_controller_if vif ();

  vending_controller #(
    .ERR_CYCLES     (8),
    .TIMEOUT_CYCLES (16),
    .TW             (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    vif.key_valid = 1'b1;
    vif.key_code  = k;
    step();
    vif.key_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    vif.coin_valid = 1'b1;
    vif.coin_code  = c;
    step();
    vif.coin_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    vif.key_valid = 1'b0;
    vif.key_code = 4'd0;
    vif.coin_valid = 1'b0;
    vif.coin_code = 2'd0;
    step();
    step();
    rst = 1'b0;
    check("rst_estado", vif.estado, 0);
    check("rst_credit", vif.credit, 0);
    check("rst_num1", vif.num1, 0);
    check("rst_dispense", vif.dispense, 0);
    check("rst_change", vif.change, 0);
    check("rst_cv", vif.change_valid, 0);

    // Coin in standby is rejected
    coin(2'd2);
    check("idle_reject", vif.coin_reject, 1);
    check("idle_credit", vif.credit, 0);
    key(4'd10);
    check("idle_reject_clr", vif.coin_reject, 0);
    check("idle_confirm_ign", vif.estado, 0);

    // Purchase code 21, price 9, pay 5+5
    key(4'd2);
    check("buy_estado_type", vif.estado, 4);
    check("buy_num1", vif.num1, 2);
    key(4'd1);
    check("buy_num2", vif.num2, 1);
    key(4'd10);
    check("buy_estado_pay", vif.estado, 3);
    coin(2'd2);
    check("buy_credit5", vif.credit, 5);
    check("buy_no_disp", vif.dispense, 0);
    coin(2'd2);
    check("buy_dispense", vif.dispense, 1);
    check("buy_cv", vif.change_valid, 1);
    check("buy_change", vif.change, 1);
    check("buy_estado_idle", vif.estado, 0);
    check("buy_credit0", vif.credit, 0);
    step();
    check("buy_disp_pulse", vif.dispense, 0);
    check("buy_cv_pulse", vif.change_valid, 0);
    check("buy_change_held", vif.change, 1);

    // Invalid code 03 -> E404 held exactly 8 cycles
    key(4'd0);
    key(4'd3);
    key(4'd10);
    check("e404_entry", vif.estado, 1);
    check("e404_num2_held", vif.num2, 3);
    for (int i = 1; i < 8; i++) begin
      step();
      check("e404_hold", vif.estado, 1);
    end
    step();
    check("e404_exit", vif.estado, 0);
    check("e404_num1_clr", vif.num1, 0);
    check("e404_num2_clr", vif.num2, 0);

    // Code 33 price 15, coins 5,2 then bad coin -> refund 7, E405
    key(4'd3);
    key(4'd3);
    key(4'd10);
    coin(2'd2);
    coin(2'd1);
    check("bad_credit7", vif.credit, 7);
    coin(2'd3);
    check("bad_cv", vif.change_valid, 1);
    check("bad_change", vif.change, 7);
    check("bad_estado", vif.estado, 2);
    check("bad_credit0", vif.credit, 0);
    check("bad_no_disp", vif.dispense, 0);
    coin(2'd0);
    check("e405_reject", vif.coin_reject, 1);
    check("e405_credit", vif.credit, 0);
    step();
    check("e405_reject_pulse", vif.coin_reject, 0);
    for (int i = 0; i < 6; i++) step();
    check("e405_exit", vif.estado, 0);

    // Code 13 price 7: credit 2, then CANCEL + 2-unit coin together -> refund 4
    key(4'd1);
    key(4'd3);
    key(4'd10);
    coin(2'd1);
    check("sim_credit2", vif.credit, 2);
    vif.key_valid = 1'b1;
    vif.key_code = 4'd11;
    vif.coin_valid = 1'b1;
    vif.coin_code = 2'd1;
    step();
    vif.key_valid = 1'b0;
    vif.coin_valid = 1'b0;
    check("sim_cv", vif.change_valid, 1);
    check("sim_change", vif.change, 4);
    check("sim_estado", vif.estado, 0);
    check("sim_no_disp", vif.dispense, 0);

    // Typing timeout after 16 idle cycles; coin during TYPE rejected
    key(4'd1);
    coin(2'd0);
    check("type_reject", vif.coin_reject, 1);
    check("type_credit", vif.credit, 0);
    for (int i = 0; i < 14; i++) step();
    check("to_before", vif.estado, 4);
    step();
    check("to_expire", vif.estado, 0);

    // Reset during PAY with credit 3
    key(4'd1);
    key(4'd3);
    key(4'd10);
    coin(2'd1);
    coin(2'd0);
    check("mid_credit3", vif.credit, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_estado", vif.estado, 0);
    check("mid_rst_credit", vif.credit, 0);
    check("mid_rst_cv", vif.change_valid, 0);
    check("mid_rst_change", vif.change, 0);
    check("mid_rst_num1", vif.num1, 0);
    check("mid_rst_num2", vif.num2, 0);
    step();
    check("post_rst_cv", vif.change_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
